// File: rtl/core_encoder.sv
// rtl/core_encoder.sv - packs decoded RV32I/M fields into instruction words behind a small output FIFO
// Optional immediate range/alignment checking: define ENCODER_CHECK_EN.
module core_encoder #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fmt,
    input  logic [6:0]      in_op,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic            err,
    output logic [15:0]     enc_count,
    output logic [7:0]      err_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [XLEN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] enc_word;
    logic            fmt_ok;
    logic            imm_ok;
    logic            legal;
    logic            is_shift;
    logic            accept;
    logic            push;
    logic            pop;

    assign is_shift = (in_op == 7'b0010011) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

    always_comb begin
        enc_word = '0;
        fmt_ok   = 1'b1;
        case (in_fmt)
            FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            FMT_I: begin
                if (is_shift)
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            end
            FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_op};
            FMT_U: enc_word = {in_imm[31:12], in_rd, in_op};
            FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef ENCODER_CHECK_EN
    // A signed value fits N bits when everything above bit N-1 is a copy of the sign bit.
    logic fits12, fits13, fits21;
    assign fits12 = (&in_imm[XLEN-1:11]) || !(|in_imm[XLEN-1:11]);
    assign fits13 = (&in_imm[XLEN-1:12]) || !(|in_imm[XLEN-1:12]);
    assign fits21 = (&in_imm[XLEN-1:20]) || !(|in_imm[XLEN-1:20]);

    always_comb begin
        imm_ok = 1'b1;
        case (in_fmt)
            FMT_I:   imm_ok = is_shift ? !(|in_imm[XLEN-1:5]) : fits12;
            FMT_S:   imm_ok = fits12;
            FMT_B:   imm_ok = fits13 && !in_imm[0];
            FMT_U:   imm_ok = !(|in_imm[11:0]);
            FMT_J:   imm_ok = fits21 && !in_imm[0];
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign legal     = fmt_ok && imm_ok;
    assign in_ready  = (count < CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;
    assign out_inst  = out_valid ? mem[rd_ptr] : '0;

    // Payload storage carries no reset; out_inst is masked while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err       <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            err <= accept && !legal;
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                enc_count <= enc_count + 16'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (accept && !legal && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule
